wb_trace_buffer: RTL

//   Observes the writeback stage of the 5-stage RISC-V pipeline and records every

---
 rtl/wb_trace_buffer_if.sv | 38 +++
 rtl/wb_trace_buffer.sv | 102 ++++++++++
 2 files changed

// File: rtl/wb_trace_buffer_if.sv
// Writeback observation and trace-drain signals of wb_trace_buffer; trc_ts exists only with WB_TRACE_TIMESTAMP_EN.
// master = core side plus trace consumer, slave = the trace buffer.
interface wb_trace_buffer_if #(
    parameter int AW = 4
);
    logic        RegWriteW;
    logic [4:0]  RDW;
    logic [31:0] ResultW;
    logic [31:0] PCPlus4W;
    logic        trc_clear;
    logic        trc_valid;
    logic        trc_ready;
    logic [4:0]  trc_rd;
    logic [31:0] trc_data;
    logic [31:0] trc_pc4;
    logic [AW:0] trc_level;
    logic [31:0] commit_cnt;
    logic [15:0] drop_cnt;
`ifdef WB_TRACE_TIMESTAMP_EN
    logic [31:0] trc_ts;
`endif

    modport master (
        output RegWriteW, RDW, ResultW, PCPlus4W, trc_clear, trc_ready,
        input  trc_valid, trc_rd, trc_data, trc_pc4, trc_level, commit_cnt, drop_cnt
`ifdef WB_TRACE_TIMESTAMP_EN
        , input trc_ts
`endif
    );

    modport slave (
        input  RegWriteW, RDW, ResultW, PCPlus4W, trc_clear, trc_ready,
        output trc_valid, trc_rd, trc_data, trc_pc4, trc_level, commit_cnt, drop_cnt
`ifdef WB_TRACE_TIMESTAMP_EN
        , output trc_ts
`endif
    );
endinterface

// File: rtl/wb_trace_buffer.sv
// Passive FIFO of retired register writes (rd, result, PC+4); WB_TRACE_TIMESTAMP_EN adds a per-entry cycle stamp.
// Entry visible one cycle after its push edge, no bypass; never stalls the core, overflow writes are counted as drops.
module wb_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    wb_trace_buffer_if.slave trc
);
    typedef struct packed {
`ifdef WB_TRACE_TIMESTAMP_EN
        logic [31:0] ts;
`endif
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc4;
    } entry_t;

    entry_t      mem_q [DEPTH];
    entry_t      wr_ent;
    entry_t      head;
    logic [AW:0] wp_q, wp_d;
    logic [AW:0] rp_q, rp_d;
    logic [31:0] commit_q, commit_d;
    logic [15:0] drop_q, drop_d;
    logic        qual, empty, full, pop, push, wr_en;
`ifdef WB_TRACE_TIMESTAMP_EN
    logic [31:0] ts_q;
`endif

    always_comb begin
        qual     = trc.RegWriteW && (trc.RDW != 5'd0);
        empty    = (wp_q == rp_q);
        full     = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
        pop      = !empty && trc.trc_ready;
        // A full FIFO still accepts the write when the head leaves on the same edge.
        push     = qual && (!full || pop);
        wr_en    = push && !trc.trc_clear;
        commit_d = commit_q + (qual ? 32'd1 : 32'd0);
        wp_d     = wp_q + (AW+1)'(push);
        rp_d     = rp_q + (AW+1)'(pop);
        drop_d   = drop_q;
        if (qual && !push && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
        if (trc.trc_clear) begin
            wp_d   = '0;
            rp_d   = '0;
            drop_d = '0;
        end
    end

    always_comb begin
        wr_ent.rd   = trc.RDW;
        wr_ent.data = trc.ResultW;
        wr_ent.pc4  = trc.PCPlus4W;
`ifdef WB_TRACE_TIMESTAMP_EN
        wr_ent.ts   = ts_q;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q     <= '0;
            rp_q     <= '0;
            commit_q <= '0;
            drop_q   <= '0;
        end else begin
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            commit_q <= commit_d;
            drop_q   <= drop_d;
        end
    end

`ifdef WB_TRACE_TIMESTAMP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ts_q <= '0;
        else      ts_q <= ts_q + 32'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wp_q[AW-1:0]] <= wr_ent;
    end

    // Head fields are forced to zero while empty so outputs read 0 under reset.
    always_comb begin
        head           = mem_q[rp_q[AW-1:0]];
        trc.trc_valid  = !empty;
        trc.trc_rd     = empty ? 5'd0  : head.rd;
        trc.trc_data   = empty ? 32'd0 : head.data;
        trc.trc_pc4    = empty ? 32'd0 : head.pc4;
`ifdef WB_TRACE_TIMESTAMP_EN
        trc.trc_ts     = empty ? 32'd0 : head.ts;
`endif
        trc.trc_level  = wp_q - rp_q;
        trc.commit_cnt = commit_q;
        trc.drop_cnt   = drop_q;
    end
endmodule
